xpb_lut_mc: RTL and testbench



---
 rtl/xpb_pkg.sv | 16 +
 rtl/xpb_lut_rd.sv | 39 +++
 rtl/xpb_lut_mc.sv | 187 ++++++++++++++++++
 tb/tb_xpb_lut_mc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb lookup-table block: default geometry and
// the load-FSM state encoding.
package xpb_pkg;

    localparam int unsigned XPB_DATA_W = 1024;
    localparam int unsigned XPB_IDX_W  = 5;
    localparam int unsigned XPB_NUM_CH = 4;
    localparam int unsigned XPB_WORD_W = 64;

    typedef enum logic [1:0] {
        XPB_IDLE   = 2'd0,
        XPB_FILL   = 2'd1,
        XPB_COMMIT = 2'd2
    } xpb_ld_state_e;

endpackage : xpb_pkg

// File: rtl/xpb_lut_rd.sv
// One registered read port on the lookup table. Index 0 is a hard-wired
// zero entry regardless of what the table holds.
module xpb_lut_rd
    import xpb_pkg::*;
#(
    parameter int unsigned DATA_W = XPB_DATA_W,
    parameter int unsigned IDX_W  = XPB_IDX_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] tbl_i [2**IDX_W],
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Select the addressed entry, forcing zero for index 0.
    always_comb begin
        data_d = '0;
        if (idx_i != '0) begin
            data_d = tbl_i[idx_i];
        end
    end

    // Capture a new result only when a read is requested; hold otherwise.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule : xpb_lut_rd

// File: rtl/xpb_lut_mc.sv
// Multi-channel lookup table with a streaming word-wise entry loader.
// NUM_CH independent 1-cycle lookup ports read a 2^IDX_W x DATA_W table;
// entries are filled least-significant word first through a valid/ready
// stream into a shadow register, then committed in a single cycle.
// Optional readback port enabled by defining XPB_LUT_RDBACK_EN.
module xpb_lut_mc
    import xpb_pkg::*;
#(
    parameter int unsigned DATA_W = XPB_DATA_W,
    parameter int unsigned IDX_W  = XPB_IDX_W,
    parameter int unsigned NUM_CH = XPB_NUM_CH,
    parameter int unsigned WORD_W = XPB_WORD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     lk_valid,
    input  logic [NUM_CH*IDX_W-1:0]  lk_idx,
    output logic [NUM_CH*DATA_W-1:0] lk_out,
    output logic                     lk_out_valid,
    input  logic                     ld_start,
    input  logic [IDX_W-1:0]         ld_addr,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [WORD_W-1:0]        ld_data,
    output logic                     ld_err
`ifdef XPB_LUT_RDBACK_EN
    ,
    input  logic                     rb_req,
    input  logic [IDX_W-1:0]         rb_idx,
    output logic [DATA_W-1:0]        rb_data,
    output logic                     rb_valid
`endif
);

    localparam int unsigned DEPTH  = 2**IDX_W;
    localparam int unsigned NWORDS = DATA_W / WORD_W;
    localparam int unsigned CNT_W  = $clog2(NWORDS) + 1;

    xpb_ld_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] shadow_sh;
    logic              err_q, err_d;
    logic              commit_en;
    logic              lk_vld_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // New words enter at the top so the first word ends up least significant.
    if (NWORDS > 1) begin : g_shift
        assign shadow_sh = {ld_data, shadow_q[DATA_W-1:WORD_W]};
    end else begin : g_noshift
        assign shadow_sh = ld_data;
    end

    // Load FSM next-state, counter, shadow and error logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        shadow_d  = shadow_q;
        err_d     = err_q;
        ld_ready  = 1'b0;
        commit_en = 1'b0;
        case (state_q)
            XPB_IDLE: begin
                if (ld_start) begin
                    if (ld_addr == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = XPB_FILL;
                        addr_d  = ld_addr;
                        cnt_d   = '0;
                    end
                end
            end
            XPB_FILL: begin
                ld_ready = 1'b1;
                if (ld_start) begin
                    err_d = 1'b1;
                end
                if (ld_valid) begin
                    shadow_d = shadow_sh;
                    if (cnt_q == CNT_W'(NWORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = XPB_COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            XPB_COMMIT: begin
                commit_en = 1'b1;
                if (ld_start) begin
                    err_d = 1'b1;
                end
                state_d = XPB_IDLE;
            end
            default: begin
                state_d = XPB_IDLE;
            end
        endcase
    end

    // Load FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= XPB_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    // Table storage; the commit write lands at the end of the COMMIT cycle,
    // so a lookup issued during COMMIT still reads the previous contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit_en && (addr_q != '0)) begin
            mem_q[addr_q] <= shadow_q;
        end
    end

    // Lookup qualifier follows the request strobe by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lk_vld_q <= 1'b0;
        end else begin
            lk_vld_q <= lk_valid;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        xpb_lut_rd #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_rd (
            .clk_i   (clk),
            .reset_i (reset),
            .en_i    (lk_valid),
            .idx_i   (lk_idx[c*IDX_W +: IDX_W]),
            .tbl_i   (mem_q),
            .data_o  (lk_out[c*DATA_W +: DATA_W])
        );
    end

    assign lk_out_valid = lk_vld_q;
    assign ld_err       = err_q;

`ifdef XPB_LUT_RDBACK_EN
    logic rb_vld_q;

    xpb_lut_rd #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_rb (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (rb_req),
        .idx_i   (rb_idx),
        .tbl_i   (mem_q),
        .data_o  (rb_data)
    );

    // Readback qualifier follows the request by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_vld_q <= 1'b0;
        end else begin
            rb_vld_q <= rb_req;
        end
    end

    assign rb_valid = rb_vld_q;
`endif

endmodule : xpb_lut_mc

// File: tb/tb_xpb_lut_mc.sv
// Directed self-checking bench for xpb_lut_mc (default geometry).
// Readback checks are included when XPB_LUT_RDBACK_EN is defined.
module tb_xpb_lut_mc;

    localparam int DW = 1024;
    localparam int IW = 5;
    localparam int NC = 4;
    localparam int WW = 64;
    localparam int NW = DW / WW;

    logic              clk = 1'b0;
    logic              reset;
    logic              lk_valid;
    logic [NC*IW-1:0]  lk_idx;
    logic [NC*DW-1:0]  lk_out;
    logic              lk_out_valid;
    logic              ld_start;
    logic [IW-1:0]     ld_addr;
    logic              ld_valid;
    logic              ld_ready;
    logic [WW-1:0]     ld_data;
    logic              ld_err;
`ifdef XPB_LUT_RDBACK_EN
    logic              rb_req;
    logic [IW-1:0]     rb_idx;
    logic [DW-1:0]     rb_data;
    logic              rb_valid;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    xpb_lut_mc #(
        .DATA_W (DW),
        .IDX_W  (IW),
        .NUM_CH (NC),
        .WORD_W (WW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lk_valid     (lk_valid),
        .lk_idx       (lk_idx),
        .lk_out       (lk_out),
        .lk_out_valid (lk_out_valid),
        .ld_start     (ld_start),
        .ld_addr      (ld_addr),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_err       (ld_err)
`ifdef XPB_LUT_RDBACK_EN
        ,
        .rb_req       (rb_req),
        .rb_idx       (rb_idx),
        .rb_data      (rb_data),
        .rb_valid     (rb_valid)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] word(input int tag, input int w);
        logic [31:0] t;
        logic [31:0] n;
        t = tag;
        n = w + 1;
        return {t, n};
    endfunction

    function automatic logic [DW-1:0] mk_entry(input int tag);
        logic [DW-1:0] v;
        v = '0;
        for (int w = 0; w < NW; w++) begin
            v[w*WW +: WW] = word(tag, w);
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] ch(input int c);
        return lk_out[c*DW +: DW];
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int fw;
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            fw = 0;
            for (int w = NW - 1; w >= 0; w--) begin
                if (obs[w*WW +: WW] !== exp[w*WW +: WW]) fw = w;
            end
            $error("FAIL %s word %0d observed %h expected %h", tag, fw,
                   obs[fw*WW +: WW], exp[fw*WW +: WW]);
        end
    endtask

    task automatic lookup(input int i0, input int i1, input int i2, input int i3);
        lk_valid = 1'b1;
        lk_idx   = {IW'(i3), IW'(i2), IW'(i1), IW'(i0)};
        tick();
        lk_valid = 1'b0;
    endtask

    // Full entry load; rnd gates ld_valid randomly, intr_at (>=0) pulses a
    // second ld_start once that many words have been accepted.
    task automatic load_entry(input int addr, input int tag, input bit rnd, input int intr_at);
        int acc;
        int cyc;
        bit intr_done;
        acc = 0;
        cyc = 0;
        intr_done = 1'b0;
        ld_start = 1'b1;
        ld_addr  = IW'(addr);
        tick();
        ld_start = 1'b0;
        while (acc < NW && cyc < 400) begin
            ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = word(tag, acc);
            if (intr_at >= 0 && acc == intr_at && !intr_done) begin
                ld_start  = 1'b1;
                ld_addr   = IW'(9);
                intr_done = 1'b1;
            end
            if (ld_valid && ld_ready) acc++;
            tick();
            ld_start = 1'b0;
            cyc++;
        end
        ld_valid = 1'b0;
        n_tests++;
        assert (acc == NW) else begin
            n_fail++;
            $error("FAIL load_words observed %0d expected %0d", acc, NW);
        end
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        lk_valid = 1'b0;
        lk_idx   = '0;
        ld_start = 1'b0;
        ld_addr  = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
`ifdef XPB_LUT_RDBACK_EN
        rb_req   = 1'b0;
        rb_idx   = '0;
`endif
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        chk1("rst_lkv", lk_out_valid, 1'b0);
        chk1("rst_err", ld_err, 1'b0);
        chk1("rst_rdy", ld_ready, 1'b0);
        for (int c = 0; c < NC; c++) chk_w($sformatf("rst_ch%0d", c), ch(c), '0);

        // Entry 1 = words 64'h1..64'h10, LS word first.
        load_entry(1, 0, 1'b0, -1);
        lookup(1, 0, 0, 0);
        chk1("lk1_vld", lk_out_valid, 1'b1);
        chk_w("lk1_ch0", ch(0), mk_entry(0));
        chk_w("lk1_ch1", ch(1), '0);
        tick();
        chk1("hold_vld", lk_out_valid, 1'b0);
        chk_w("hold_ch0", ch(0), mk_entry(0));

        // Fill entries 1..31, then index 0 on every channel reads zero.
        for (int a = 1; a < 32; a++) load_entry(a, a, 1'b0, -1);
        lookup(0, 0, 0, 0);
        for (int c = 0; c < NC; c++) chk_w($sformatf("zero_ch%0d", c), ch(c), '0);
        lookup(1, 2, 17, 31);
        chk_w("mix_ch0", ch(0), mk_entry(1));
        chk_w("mix_ch1", ch(1), mk_entry(2));
        chk_w("mix_ch2", ch(2), mk_entry(17));
        chk_w("mix_ch3", ch(3), mk_entry(31));
        lookup(5, 5, 5, 5);
        for (int c = 0; c < NC; c++) chk_w($sformatf("same_ch%0d", c), ch(c), mk_entry(5));

        // Load to entry 0 is refused and flagged.
        ld_start = 1'b1;
        ld_addr  = '0;
        tick();
        ld_start = 1'b0;
        chk1("a0_err", ld_err, 1'b1);
        chk1("a0_rdy", ld_ready, 1'b0);
        lookup(0, 1, 31, 0);
        chk_w("a0_ch0", ch(0), '0);
        chk_w("a0_ch1", ch(1), mk_entry(1));
        chk_w("a0_ch2", ch(2), mk_entry(31));

        // Reload entry 5 (A -> B) with a lookup of index 5 every cycle.
        lk_valid = 1'b1;
        lk_idx   = {IW'(0), IW'(0), IW'(0), IW'(5)};
        ld_start = 1'b1;
        ld_addr  = IW'(5);
        tick();
        ld_start = 1'b0;
        chk_w("rl_idle", ch(0), mk_entry(5));
        for (int w = 0; w < NW; w++) begin
            ld_valid = 1'b1;
            ld_data  = word(100, w);
            tick();
            chk_w($sformatf("rl_fill%0d", w), ch(0), mk_entry(5));
        end
        ld_valid = 1'b0;
        chk1("rl_commit_rdy", ld_ready, 1'b0);
        tick();
        chk_w("rl_commit", ch(0), mk_entry(5));
        tick();
        chk_w("rl_new", ch(0), mk_entry(100));
        tick();
        chk_w("rl_new2", ch(0), mk_entry(100));
        lk_valid = 1'b0;

        // Random ld_valid gaps plus a second ld_start mid-fill.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("rst2_err", ld_err, 1'b0);
        load_entry(7, 7, 1'b1, 4);
        chk1("mid_err", ld_err, 1'b1);
        chk1("mid_rdy", ld_ready, 1'b0);
        lookup(7, 9, 0, 0);
        chk_w("mid_e7", ch(0), mk_entry(7));
        chk_w("mid_e9", ch(1), '0);

        // Reset after 7 accepted words aborts the load.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ld_start = 1'b1;
        ld_addr  = IW'(3);
        tick();
        ld_start = 1'b0;
        chk1("ab_rdy_fill", ld_ready, 1'b1);
        for (int w = 0; w < 7; w++) begin
            ld_valid = 1'b1;
            ld_data  = word(3, w);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        ld_valid = 1'b0;
        chk1("ab_rdy", ld_ready, 1'b0);
        chk1("ab_err", ld_err, 1'b0);
        lookup(3, 0, 0, 0);
        chk_w("ab_e3", ch(0), '0);
        load_entry(3, 3, 1'b0, -1);
        chk1("ab_err2", ld_err, 1'b0);
        lookup(3, 0, 0, 0);
        chk_w("ab_e3_new", ch(0), mk_entry(3));

`ifdef XPB_LUT_RDBACK_EN
        rb_req = 1'b1;
        rb_idx = IW'(3);
        tick();
        rb_req = 1'b0;
        chk1("rb_vld", rb_valid, 1'b1);
        chk_w("rb_e3", rb_data, mk_entry(3));
        rb_req = 1'b1;
        rb_idx = '0;
        tick();
        rb_req = 1'b0;
        chk_w("rb_e0", rb_data, '0);
        tick();
        chk1("rb_vld_off", rb_valid, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_xpb_lut_mc
